// File: rtl/load_resp_pkg.sv
// rtl/load_resp_pkg.sv - shared state encoding, default sizes and count-width helper for load_responder
package load_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        ERR    = 2'b10
    } state_t;

    localparam int DEF_DW    = 8;
    localparam int DEF_AW    = 16;
    localparam int DEF_DEPTH = 4;

    // Occupancy must represent 0..DEPTH inclusive, hence one bit above the pointer width.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// rtl/resp_fifo.sv - DEPTH x DW circular sample buffer with occupancy count
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               clears pointers and count on the next edge
//   push, wdata         write request and sample (dropped when full)
//   pop                 read request (ignored when empty)
//   rdata               current head sample
//   count, full, empty  occupancy status
module resp_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          push_ok;
    logic          pop_ok;

    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign count = cnt;
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/load_responder.sv
// rtl/load_responder.sv - datapath responder: sample FIFO, load-driven accumulator, error/overflow flags
// Optional feature macro: LOAD_RESPONDER_SATURATE_EN (accumulator clamps instead of wrapping).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   flush                      clears FIFO, accumulator, flags; returns to IDLE
//   load                       pop head and accumulate it
//   controller_inuse           controller busy; enables ACTIVE
//   in_valid, in_data, in_ready  upstream sample handshake
//   ready                      head sample available for load
//   error, ov_flag             sticky protocol-error and overflow flags
//   acc_out                    running sum
//   count                      FIFO occupancy
module load_responder
    import load_resp_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          load,
    input  logic                          controller_inuse,
    input  logic                          in_valid,
    input  logic [DW-1:0]                 in_data,
    output logic                          in_ready,
    output logic                          ready,
    output logic                          error,
    output logic                          ov_flag,
    output logic [AW-1:0]                 acc_out,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int CW = cnt_width(DEPTH);

    state_t        state;
    state_t        state_next;
    logic [DW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic [AW:0]   sum;
    logic          carry;
    logic [AW-1:0] acc_next;

    resp_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (in_valid & in_ready),
        .wdata (in_data),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst || flush) state <= IDLE;
        else              state <= state_next;
    end

    // Next-state logic; a load on an empty FIFO outranks the controller going idle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (controller_inuse) state_next = ACTIVE;
            ACTIVE: begin
                if (load && fifo_empty)     state_next = ERR;
                else if (!controller_inuse) state_next = IDLE;
            end
            ERR:     state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; in_ready depends on occupancy only so load never feeds back upstream.
    always_comb begin
        ready    = (state == ACTIVE) && !fifo_empty;
        in_ready = !fifo_full;
    end

    // Loads are honoured only while a sample is offered; IDLE and ERR drop them silently.
    assign pop   = load & ready;
    assign sum   = {1'b0, acc_out} + {{(AW + 1 - DW){1'b0}}, head};
    assign carry = sum[AW];

`ifdef LOAD_RESPONDER_SATURATE_EN
    // Once clamped, any non-zero addend carries again, so the value holds at all-ones.
    assign acc_next = carry ? {AW{1'b1}} : sum[AW-1:0];
`else
    assign acc_next = sum[AW-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            acc_out <= '0;
            ov_flag <= 1'b0;
            error   <= 1'b0;
        end else begin
            error <= (state_next == ERR);
            if (pop) begin
                acc_out <= acc_next;
                if (carry) ov_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_load_responder.sv
// tb/tb_load_responder.sv - scoreboard bench for load_responder (DW=8, AW=16, DEPTH=4)
module tb_load_responder;

`ifdef LOAD_RESPONDER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        load = 1'b0;
    logic        controller_inuse = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        ready;
    logic        error;
    logic        ov_flag;
    logic [15:0] acc_out;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int mq[$];
    int exp_acc[$];
    int m_state = 0;
    int macc = 0;
    bit m_ov = 1'b0;

    load_responder dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .load             (load),
        .controller_inuse (controller_inuse),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .ready            (ready),
        .error            (error),
        .ov_flag          (ov_flag),
        .acc_out          (acc_out),
        .count            (count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1);
    end

    // Drive one cycle of stimulus, advance the model, then wait past the edge.
    task automatic cycle(input bit v, input int d, input bit ld);
        bit do_pop;
        bit do_push;
        int h;
        int s;
        in_valid = v;
        in_data  = 8'(d);
        load     = ld;
        if (rst || flush) begin
            mq.delete();
            macc    = 0;
            m_ov    = 1'b0;
            m_state = 0;
        end else begin
            do_pop  = ld && (m_state == 1) && (mq.size() != 0);
            do_push = v && (mq.size() != 4);
            case (m_state)
                0: if (controller_inuse) m_state = 1;
                1: begin
                    if (ld && mq.size() == 0)  m_state = 2;
                    else if (!controller_inuse) m_state = 0;
                end
                default: m_state = 2;
            endcase
            if (do_pop) begin
                h = mq.pop_front();
                s = macc + h;
                if (s > 65535) begin
                    m_ov = 1'b1;
                    macc = SAT ? 65535 : s - 65536;
                end else begin
                    macc = s;
                end
                exp_acc.push_back(macc);
            end
            if (do_push) mq.push_back(d & 255);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cycle(0, 0, 0);
        flush = 1'b0;
        exp_acc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        rst = 1'b0;
        n_checks++; if (acc_out !== 16'h0) begin n_errors++; $display("FAIL reset_acc: got %h want 0000", acc_out); end
        n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL reset_error: got %b want 0", error); end
        n_checks++; if (ov_flag !== 1'b0) begin n_errors++; $display("FAIL reset_ov: got %b want 0", ov_flag); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", count); end
    endtask

    task automatic test_basic_loads();
        int  pv[3]   = '{5, 7, 0};
        bit  pvld[3] = '{1'b1, 1'b1, 1'b0};
        int  e;
        do_flush();
        controller_inuse = 1'b1;
        cycle(1, 3, 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL basic_ready_before_pop%0d: got %b want 1", i, ready); end
            cycle(pvld[i], pv[i], 1);
            if (exp_acc.size() != 0) begin
                e = exp_acc.pop_front();
                n_checks++; if (acc_out !== 16'(e)) begin n_errors++; $display("FAIL basic_acc%0d: got %0d want %0d", i, acc_out, e); end
            end
        end
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL basic_ready_after: got %b want 0", ready); end
        n_checks++; if (acc_out !== 16'd15) begin n_errors++; $display("FAIL basic_sum: got %0d want 15", acc_out); end
        n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL basic_error: got %b want 0", error); end
    endtask

    task automatic test_full();
        int e;
        do_flush();
        controller_inuse = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1, 10 + i, 0);
        n_checks++; if (count !== 3'd4) begin n_errors++; $display("FAIL full_count: got %0d want 4", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL full_idle_ready: got %b want 0", ready); end
        controller_inuse = 1'b1;
        cycle(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1);
            if (i == 0) begin
                n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL full_in_ready_after_pop: got %b want 1", in_ready); end
                n_checks++; if (count !== 3'(mq.size())) begin n_errors++; $display("FAIL full_count_after_pop: got %0d want %0d", count, mq.size()); end
            end
            if (exp_acc.size() != 0) begin
                e = exp_acc.pop_front();
                n_checks++; if (acc_out !== 16'(e)) begin n_errors++; $display("FAIL full_acc%0d: got %0d want %0d", i, acc_out, e); end
            end
        end
        n_checks++; if (acc_out !== 16'd46) begin n_errors++; $display("FAIL full_dropped_sum: got %0d want 46", acc_out); end
    endtask

    task automatic test_error();
        do_flush();
        controller_inuse = 1'b0;
        cycle(0, 0, 1);
        n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL idle_load_error: got %b want 0", error); end
        controller_inuse = 1'b1;
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL err_flag: got %b want 1", error); end
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL err_ready: got %b want 0", ready); end
        cycle(1, 9, 1);
        n_checks++; if (count !== 3'd1) begin n_errors++; $display("FAIL err_push_count: got %0d want 1", count); end
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL err_ready_nonempty: got %b want 0", ready); end
        n_checks++; if (acc_out !== 16'd0) begin n_errors++; $display("FAIL err_load_ignored: got %0d want 0", acc_out); end
        n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %b want 1", error); end
        controller_inuse = 1'b0;
        do_flush();
        n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL flush_error: got %b want 0", error); end
        n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL flush_count: got %0d want 0", count); end
        n_checks++; if (acc_out !== 16'd0) begin n_errors++; $display("FAIL flush_acc: got %0d want 0", acc_out); end
    endtask

    task automatic test_overflow();
        int e;
        do_flush();
        controller_inuse = 1'b1;
        cycle(1, 255, 0);
        for (int i = 0; i < 258; i++) begin
            if (i < 255)       cycle(1, 255, 1);
            else if (i == 255) cycle(1, 240, 1);
            else if (i == 256) cycle(1, 32, 1);
            else               cycle(0, 0, 1);
            if (i == 256) begin
                n_checks++; if (acc_out !== 16'hFFF0) begin n_errors++; $display("FAIL ovf_preload: got %h want fff0", acc_out); end
                n_checks++; if (ov_flag !== 1'b0) begin n_errors++; $display("FAIL ovf_early: got %b want 0", ov_flag); end
            end
            if (exp_acc.size() != 0) begin
                e = exp_acc.pop_front();
                n_checks++; if (acc_out !== 16'(e)) begin n_errors++; $display("FAIL ovf_acc%0d: got %h want %h", i, acc_out, e); end
            end
        end
        n_checks++; if (ov_flag !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b want 1", ov_flag); end
        n_checks++; if (acc_out !== (SAT ? 16'hFFFF : 16'h0010)) begin n_errors++; $display("FAIL ovf_value: got %h want %h", acc_out, SAT ? 16'hFFFF : 16'h0010); end
        cycle(1, 1, 0);
        cycle(0, 0, 1);
        if (exp_acc.size() != 0) begin
            e = exp_acc.pop_front();
            n_checks++; if (acc_out !== 16'(e)) begin n_errors++; $display("FAIL ovf_after: got %h want %h", acc_out, e); end
        end
        n_checks++; if (ov_flag !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %b want 1", ov_flag); end
    endtask

    task automatic test_back_to_back();
        int e;
        do_flush();
        controller_inuse = 1'b1;
        cycle(1, 6, 0);
        cycle(1, 8, 1);
        n_checks++; if (count !== 3'd1) begin n_errors++; $display("FAIL b2b_count: got %0d want 1", count); end
        if (exp_acc.size() != 0) begin
            e = exp_acc.pop_front();
            n_checks++; if (acc_out !== 16'(e)) begin n_errors++; $display("FAIL b2b_acc0: got %0d want %0d", acc_out, e); end
        end
        cycle(0, 0, 1);
        if (exp_acc.size() != 0) begin
            e = exp_acc.pop_front();
            n_checks++; if (acc_out !== 16'(e)) begin n_errors++; $display("FAIL b2b_acc1: got %0d want %0d", acc_out, e); end
        end
        n_checks++; if (acc_out !== 16'd14) begin n_errors++; $display("FAIL b2b_sum: got %0d want 14", acc_out); end
        n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL b2b_drained: got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        do_flush();
        controller_inuse = 1'b1;
        cycle(1, 4, 0);
        cycle(1, 5, 1);
        cycle(1, 20, 1);
        cycle(1, 21, 0);
        exp_acc.delete();
        n_checks++; if (count !== 3'd2) begin n_errors++; $display("FAIL mid_pre_count: got %0d want 2", count); end
        n_checks++; if (acc_out !== 16'd9) begin n_errors++; $display("FAIL mid_pre_acc: got %0d want 9", acc_out); end
        rst = 1'b1;
        cycle(1, 30, 1);
        rst = 1'b0;
        in_valid = 1'b0;
        load = 1'b0;
        n_checks++; if (count !== 3'd0) begin n_errors++; $display("FAIL mid_count: got %0d want 0", count); end
        n_checks++; if (acc_out !== 16'd0) begin n_errors++; $display("FAIL mid_acc: got %0d want 0", acc_out); end
        n_checks++; if (ready !== 1'b0) begin n_errors++; $display("FAIL mid_ready: got %b want 0", ready); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        n_checks++; if (error !== 1'b0 || ov_flag !== 1'b0) begin n_errors++; $display("FAIL mid_flags: got %b%b want 00", error, ov_flag); end
    endtask

    initial begin
        test_reset();
        test_basic_loads();
        test_full();
        test_error();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
